// File: rtl/corr_readout_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : corr_readout_scheduler
//  Description : Correlator sequencer. Clears the accumulator bank, runs an
//                integration window, freezes the accumulators, then reads
//                every baseline and streams a framed byte packet
//                (A5 header, MSB-first data bytes, XOR checksum) to a
//                byte-wide UART transmitter over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module corr_readout_scheduler #(
    parameter int CLK_FREQUENCY = 50000000,
    parameter int RESOLUTION    = 12,
    parameter int NUM_INPUTS    = 10,
    parameter int INTEG_CYCLES  = 5000000,
    localparam int c_num_ch     = NUM_INPUTS * (NUM_INPUTS - 1) / 2,
    localparam int c_sel_w      = (c_num_ch > 1) ? $clog2(c_num_ch) : 1,
    localparam int c_nb         = (RESOLUTION + 7) / 8,
    localparam int c_byte_w     = c_nb * 8,
    localparam int c_idx_w      = (c_nb > 1) ? $clog2(c_nb) : 1,
    localparam int c_cnt_w      = $clog2(INTEG_CYCLES) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    output logic                  o_acc_clear,
    output logic                  o_acc_hold,
    output logic [c_sel_w-1:0]    o_acc_sel,
    input  logic [RESOLUTION-1:0] i_acc_data,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_frame_done
);

    // Reject parameter sets that cannot form a valid window or clock.
    if (INTEG_CYCLES < 1 || CLK_FREQUENCY < 1 || NUM_INPUTS < 2) begin : g_param_check
        $error("corr_readout_scheduler: INTEG_CYCLES, CLK_FREQUENCY must be >= 1 and NUM_INPUTS >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_INTEG = 3'd2,
        S_HDR   = 3'd3,
        S_FETCH = 3'd4,
        S_BYTE  = 3'd5,
        S_CSUM  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t                r_state;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_sel_w-1:0]    r_sel;
    logic [c_idx_w-1:0]    r_idx;
    logic [c_byte_w-1:0]   r_shift;
    logic [7:0]            r_csum;

    logic                  w_xfer;
    logic [c_byte_w-1:0]   w_acc_ext;
    logic                  w_last_sel;

    // A byte moves only when both sides agree at the clock edge.
    assign w_xfer     = o_tx_valid & i_tx_ready;
    assign w_acc_ext  = c_byte_w'(i_acc_data);
    assign w_last_sel = (r_sel == c_sel_w'(c_num_ch - 1));
    assign o_acc_sel  = r_sel;

    // Frame sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_sel        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_csum       <= '0;
            o_acc_clear  <= 1'b0;
            o_acc_hold   <= 1'b0;
            o_tx_data    <= 8'h00;
            o_tx_valid   <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            // Single-cycle strobes default low; set only on state entry.
            o_acc_clear  <= 1'b0;
            o_frame_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_enable) begin
                        r_state     <= S_CLEAR;
                        o_acc_clear <= 1'b1;
                        o_busy      <= 1'b1;
                    end
                end

                S_CLEAR: begin
                    r_cnt   <= c_cnt_w'(INTEG_CYCLES - 1);
                    r_state <= S_INTEG;
                end

                S_INTEG: begin
                    // Dropping enable abandons the window before anything is sent.
                    if (!i_enable) begin
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state    <= S_HDR;
                        o_acc_hold <= 1'b1;
                        o_tx_data  <= 8'hA5;
                        o_tx_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end

                S_HDR: begin
                    if (w_xfer) begin
                        o_tx_valid <= 1'b0;
                        r_sel      <= '0;
                        r_csum     <= 8'h00;
                        r_state    <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    // acc_sel settled last cycle, so acc_data is valid now.
                    o_tx_data  <= w_acc_ext[c_byte_w-1 -: 8];
                    r_shift    <= w_acc_ext << 8;
                    r_idx      <= c_idx_w'(c_nb - 1);
                    o_tx_valid <= 1'b1;
                    r_state    <= S_BYTE;
                end

                S_BYTE: begin
                    if (w_xfer) begin
                        r_csum <= r_csum ^ o_tx_data;
                        if (r_idx != '0) begin
                            r_idx     <= r_idx - c_idx_w'(1);
                            o_tx_data <= r_shift[c_byte_w-1 -: 8];
                            r_shift   <= r_shift << 8;
                        end else if (w_last_sel) begin
                            // Checksum includes the byte being accepted now.
                            o_tx_data <= r_csum ^ o_tx_data;
                            r_state   <= S_CSUM;
                        end else begin
                            r_sel      <= r_sel + c_sel_w'(1);
                            o_tx_valid <= 1'b0;
                            r_state    <= S_FETCH;
                        end
                    end
                end

                S_CSUM: begin
                    if (w_xfer) begin
                        o_tx_valid   <= 1'b0;
                        o_frame_done <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end

                S_DONE: begin
                    o_acc_hold <= 1'b0;
                    if (i_enable) begin
                        r_state     <= S_CLEAR;
                        o_acc_clear <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    o_tx_valid <= 1'b0;
                    o_acc_hold <= 1'b0;
                    o_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_corr_readout_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_corr_readout_scheduler
//  Description : Self-checking bench for corr_readout_scheduler (3 inputs,
//                10-cycle window). Cycle table for reset/start-up timing,
//                hand-written backpressure/enable/reset sequences, and
//                randomized frames checked against a byte-list model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_corr_readout_scheduler;

    localparam int NUM_INPUTS   = 3;
    localparam int INTEG_CYCLES = 10;
    localparam int RESOLUTION   = 12;
    localparam int NUM_CH       = NUM_INPUTS * (NUM_INPUTS - 1) / 2;
    localparam int NB           = (RESOLUTION + 7) / 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        tx_ready = 1'b0;
    logic        acc_clear, acc_hold, tx_valid, busy, frame_done;
    logic [1:0]  acc_sel;
    logic [11:0] acc_data;
    logic [7:0]  tx_data;

    logic [11:0] acc_mem [NUM_CH];

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic [7:0] t2_frame[$];

    always #5 clk = ~clk;

    // Accumulator read mux: combinational view of the selected baseline.
    always_comb begin
        acc_data = 12'h000;
        for (int c = 0; c < NUM_CH; c++)
            if (int'(acc_sel) == c) acc_data = acc_mem[c];
    end

    corr_readout_scheduler #(
        .CLK_FREQUENCY(50000000),
        .RESOLUTION   (RESOLUTION),
        .NUM_INPUTS   (NUM_INPUTS),
        .INTEG_CYCLES (INTEG_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_enable    (enable),
        .o_acc_clear (acc_clear),
        .o_acc_hold  (acc_hold),
        .o_acc_sel   (acc_sel),
        .i_acc_data  (acc_data),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready),
        .o_busy      (busy),
        .o_frame_done(frame_done)
    );

    // Capture accepted bytes and check the hold-while-stalled rule.
    logic       p_valid = 1'b0, p_ready = 1'b0, p_rst = 1'b1;
    logic [7:0] p_data = 8'h00;
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) got.push_back(tx_data);
        if (p_valid && !p_ready && !p_rst) begin
            n_vec++;
            if (!tx_valid || tx_data != p_data) begin
                n_err++;
                $display("FAIL stall_hold: valid=%0b data=%02h, required valid=1 data=%02h",
                         tx_valid, tx_data, p_data);
            end
        end
        p_valid = tx_valid;
        p_ready = tx_ready;
        p_rst   = rst;
        p_data  = tx_data;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst, en, rdy;
        logic       clr, hold, valid, busy, done;
        logic [1:0] sel;
        logic [7:0] data;
        logic       chk;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input logic r, e, y, c, h, v, b, d,
                                input logic [1:0] s, input logic [7:0] dt, input logic k);
        vec_t t;
        t.rst = r; t.en = e; t.rdy = y;
        t.clr = c; t.hold = h; t.valid = v; t.busy = b; t.done = d;
        t.sel = s; t.data = dt; t.chk = k;
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; tx_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        got.delete();
    endtask

    // Reference frame: header, every baseline MSB-first, XOR of data bytes.
    task automatic build_expected();
        logic [7:0]  cs;
        logic [31:0] w;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        cs = 8'h00;
        for (int c = 0; c < NUM_CH; c++)
            for (int b = NB - 1; b >= 0; b--) begin
                w = 32'(acc_mem[c]) >> (8 * b);
                exp_q.push_back(w[7:0]);
                cs = cs ^ w[7:0];
            end
        exp_q.push_back(cs);
    endtask

    task automatic cmp_frame(input string name, input logic [7:0] ref_q[$]);
        int bad;
        bad = -1;
        for (int i = 0; i < ref_q.size() && i < got.size(); i++)
            if (bad < 0 && got[i] != ref_q[i]) bad = i;
        n_vec++;
        if (got.size() != ref_q.size() || bad >= 0) begin
            n_err++;
            if (bad >= 0)
                $display("FAIL %s: byte %0d is %02h, required %02h (len %0d vs %0d)",
                         name, bad, got[bad], ref_q[bad], got.size(), ref_q.size());
            else
                $display("FAIL %s: frame length %0d, required %0d", name, got.size(), ref_q.size());
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0b, required %0b", name, act, req);
        end
    endtask

    // Run until frame_done (bounded), then confirm it was a single pulse.
    task automatic wait_done(input int pct, input bit drop_en, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tx_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            if (drop_en && got.size() > 0) enable = 1'b0;
            step();
            if (frame_done) seen = 1'b1;
        end
        check_bit("frame_done_seen", seen, 1'b1);
        if (seen) begin
            step();
            check_bit("frame_done_pulse", frame_done, 1'b0);
            check_bit("hold_released", acc_hold, 1'b0);
        end
    endtask

    initial begin
        int vcount;
        t2_frame = '{8'hA5, 8'h00, 8'h23, 8'h01, 8'h23, 8'h02, 8'h23, 8'h20};
        for (int c = 0; c < NUM_CH; c++) acc_mem[c] = 12'(32'h100 * c + 32'h23);

        // ---- cycle table: reset, start-up, window length, first baselines
        tbl[0]  = mk(1,1,1, 0,0,0,0,0, 2'd0, 8'h00, 1);
        tbl[1]  = mk(1,1,1, 0,0,0,0,0, 2'd0, 8'h00, 1);
        tbl[2]  = mk(0,1,1, 1,0,0,1,0, 2'd0, 8'h00, 1);
        for (int i = 3; i <= 12; i++)
            tbl[i] = mk(0,1,1, 0,0,0,1,0, 2'd0, 8'h00, 1);
        tbl[13] = mk(0,1,1, 0,1,1,1,0, 2'd0, 8'hA5, 1);
        tbl[14] = mk(0,1,1, 0,1,0,1,0, 2'd0, 8'h00, 0);
        tbl[15] = mk(0,1,1, 0,1,1,1,0, 2'd0, 8'h00, 1);
        tbl[16] = mk(0,1,0, 0,1,1,1,0, 2'd0, 8'h00, 1);
        tbl[17] = mk(0,1,1, 0,1,1,1,0, 2'd0, 8'h23, 1);
        tbl[18] = mk(0,1,1, 0,1,0,1,0, 2'd1, 8'h00, 0);
        tbl[19] = mk(0,1,1, 0,1,1,1,0, 2'd1, 8'h01, 1);

        got.delete();
        for (int i = 0; i < 20; i++) begin
            rst = tbl[i].rst; enable = tbl[i].en; tx_ready = tbl[i].rdy;
            step();
            n_vec++;
            if (acc_clear !== tbl[i].clr || acc_hold !== tbl[i].hold ||
                tx_valid !== tbl[i].valid || busy !== tbl[i].busy ||
                frame_done !== tbl[i].done || acc_sel !== tbl[i].sel ||
                (tbl[i].chk && tx_data !== tbl[i].data)) begin
                n_err++;
                $display("FAIL vec%0d: clr=%0b hold=%0b valid=%0b busy=%0b done=%0b sel=%0d data=%02h, required clr=%0b hold=%0b valid=%0b busy=%0b done=%0b sel=%0d data=%02h",
                         i, acc_clear, acc_hold, tx_valid, busy, frame_done, acc_sel, tx_data,
                         tbl[i].clr, tbl[i].hold, tbl[i].valid, tbl[i].busy, tbl[i].done,
                         tbl[i].sel, tbl[i].data);
            end
        end
        // enable dropped mid-readout: frame still completes, then idle
        enable = 1'b0;
        wait_done(100, 1'b0, 300);
        cmp_frame("t2_frame", t2_frame);
        check_bit("t2_idle_busy", busy, 1'b0);

        // ---- backpressure: 50-cycle stall mid-BYTE, then random ready
        do_reset();
        enable = 1'b1; tx_ready = 1'b1;
        for (int i = 0; i < 100 && got.size() < 2; i++) step();
        tx_ready = 1'b0;
        enable   = 1'b0;
        for (int i = 0; i < 50; i++) step();
        check_bit("stall_valid", tx_valid, 1'b1);
        n_vec++;
        if (tx_data !== 8'h23) begin
            n_err++;
            $display("FAIL stall_data: got %02h, required 23", tx_data);
        end
        wait_done(50, 1'b0, 600);
        cmp_frame("backpressure_frame", t2_frame);
        check_bit("bp_idle_busy", busy, 1'b0);

        // ---- enable drop at INTEG cycle 5: window aborted, nothing sent
        do_reset();
        enable = 1'b1; tx_ready = 1'b1;
        step();                               // CLEAR
        check_bit("abort_clear", acc_clear, 1'b1);
        for (int i = 0; i < 5; i++) step();   // INTEG cycles 1..5
        enable = 1'b0;
        step();
        check_bit("abort_busy", busy, 1'b0);
        vcount = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (tx_valid) vcount++;
        end
        n_vec++;
        if (vcount != 0 || got.size() != 0) begin
            n_err++;
            $display("FAIL abort_no_tx: valid cycles %0d bytes %0d, required 0 and 0", vcount, got.size());
        end

        // ---- reset after 4 bytes, then a clean restart
        do_reset();
        enable = 1'b1; tx_ready = 1'b1;
        for (int i = 0; i < 100 && got.size() < 4; i++) step();
        rst = 1'b1;
        step();
        check_bit("rst_mid_valid", tx_valid, 1'b0);
        check_bit("rst_mid_hold", acc_hold, 1'b0);
        check_bit("rst_mid_busy", busy, 1'b0);
        rst = 1'b0;
        got.delete();
        wait_done(100, 1'b0, 300);
        cmp_frame("restart_frame", t2_frame);
        enable = 1'b0;

        // ---- randomized frames against the byte-list model
        for (int it = 0; it < 6; it++) begin
            do_reset();
            for (int c = 0; c < NUM_CH; c++) acc_mem[c] = 12'($urandom);
            build_expected();
            enable = 1'b1;
            wait_done(int'($urandom_range(30, 100)), 1'b1, 600);
            cmp_frame("random_frame", exp_q);
            check_bit("random_idle_busy", busy, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
